fifo_reader: RTL and testbench
==============================

# fifo_reader

Burst drain engine for the consumer side of the synchronous `fifo`. On a `start` pulse it pops exactly `burst_len` words through the FIFO's `read_en`/`data_out`/`empty` port. It absorbs the FIFO's one-cycle registered read latency in a 2-entry skid buffer and presents the words downstream on a valid/ready stream. It sits between a `fifo` instance and any stream consumer, and pulses `done` once the last word of the burst has been accepted downstream.

## Interface
- `DATA_WIDTH`, 8: word width; must match the FIFO's `FIFO_WIDTH`.
- `LEN_WIDTH`, 6: width of `burst_len`; maximum burst is 2**LEN_WIDTH-1 words.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `burst_len`  in  LEN_WIDTH  words to drain; captured when `start` is accepted.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` is high.
- `done`  out  1  single-cycle pulse at burst completion.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_read_en`  out  1  FIFO `read_en`.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`; valid in the cycle after a read is issued.
- `m_valid`  out  1  downstream word valid.
- `m_data`  out  DATA_WIDTH  downstream word (head of skid buffer).
- `m_ready`  in  1  downstream accept.

## Operation
- Internal state: `remaining` (LEN_WIDTH), `inflight` (1 bit), `occ` (0..2, skid occupancy), FSM state.
- FSM has three states, IDLE, READ and FLUSH, with these transitions:
  - IDLE -> READ on `start` with `burst_len`!=0. `remaining` loads `burst_len`.
  - IDLE + `start` with `burst_len`==0 does not enter READ: `done` pulses next cycle and no read is issued.
  - READ -> FLUSH when `remaining` reaches 0.
  - FLUSH -> IDLE when `inflight`==0 and `occ`==0. `done` pulses the following cycle.
- `start` outside IDLE is ignored; `burst_len` changes mid-burst have no effect.
- `fifo_read_en` is combinational and asserts only when all of the following hold:
  - state==READ
  - `remaining`!=0
  - `!fifo_empty`
  - (`occ` + `inflight` − (`m_valid`&&`m_ready`)) < 2
- Reading never happens while the FIFO is empty, and the skid buffer never overflows.
- On each issued read: `remaining` decrements and `inflight` sets. On the next edge, `fifo_data` is written to the skid tail and `inflight` clears unless a new read was issued.
- The skid buffer is a 2-entry in-order queue. `m_valid` = (`occ`!=0). `m_data` = head entry. A pop occurs on `m_valid`&&`m_ready`.
- Push and pop in the same cycle leave `occ` unchanged, and order is preserved.
- Reset (any time, including mid-burst):
  - FSM -> IDLE; `remaining`, `inflight`, `occ` -> 0; skid contents discarded.
  - Outputs: `fifo_read_en`=0, `m_valid`=0, `m_data`=0, `busy`=0, `done`=0.
  - Words already popped from the FIFO are lost.

## Timing
- `start` accepted at edge E0. At cycle E0+1: `busy`=1 and the first `fifo_read_en` (if not empty).
- Read issued in cycle t. `fifo_data` is sampled at the end of t+1, and `m_valid`=1 in cycle t+2.
- Start-to-first-`m_valid` latency is 3 cycles with a non-empty FIFO and idle skid.
- Sustained throughput is 1 word/cycle with `m_ready` held high and the FIFO non-empty.
- With `m_ready` low, at most 2 reads are outstanding: `fifo_read_en` drops once `occ`+`inflight`=2.
- Final handshake in cycle k: `done`=1 and `busy`=0 in cycle k+1. A new `start` can be accepted in cycle k+1.
- `m_valid`, once high, stays high with `m_data` stable until accepted.

## Configuration
- `FIFO_READER_WORDCNT_EN` defined:
  - Adds output `word_count` (16 bits), the total downstream handshakes since reset.
  - It saturates at 16'hFFFF and is reset to 0 by `rst` only, not by `start`.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset, FIFO preloaded with 0x11..0x14, `start` with `burst_len`=4, `m_ready`=1 -> `fifo_read_en` high cycles 1–4, `m_valid` cycles 3–6 carrying 0x11,0x12,0x13,0x14; `done` pulse cycle 7; FIFO holds 0 words.
- Same as above but `m_ready`=0 until cycle 10 -> exactly 2 reads issued, `m_data`=0x11 held stable; after release, remaining words delivered in order and `done` follows the 4th handshake.
- FIFO empty at `start` (`burst_len`=2), write 0xA5 at cycle 5 and 0x5A at cycle 8 -> no `fifo_read_en` while `empty`, both words delivered in order, then `done`.
- `start` with `burst_len`=0 -> `done` high next cycle, `busy` never high, no `fifo_read_en`.
- `rst` asserted mid-burst with `occ`=2 -> same cycle `m_valid`=0, `busy`=0, `fifo_read_en`=0. A subsequent `start` with `burst_len`=1 delivers the next FIFO word.
- With `FIFO_READER_WORDCNT_EN`: two bursts of 3 and 5 words -> `word_count`=8. A second `start` during `busy` is ignored.

Source files
------------

// File: rtl/fifo_reader.sv
// fifo_reader: burst drain engine from a registered-read FIFO into a 2-entry skid buffer / valid-ready stream.
// Optional FIFO_READER_WORDCNT_EN adds a saturating 16-bit downstream handshake counter.
module fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_READER_WORDCNT_EN
  ,
  output logic [15:0]           word_count
`endif
);
  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;
  state_t                state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  inflight;
  logic [1:0]            occ;
  logic [1:0]            occ_next;
  logic [DATA_WIDTH-1:0] d0;
  logic [DATA_WIDTH-1:0] d1;
  logic                  pop;
  assign m_valid  = occ != 2'd0;
  assign m_data   = d0;
  assign pop      = m_valid && m_ready;
  assign busy     = state != IDLE;
  // the word in flight always lands next edge, so it counts toward occupancy now
  assign occ_next = occ + {1'b0, inflight} - {1'b0, pop};
  assign fifo_read_en = state == READ && remaining != '0 && !fifo_empty && occ_next < 2'd2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      inflight  <= 1'b0;
      occ       <= 2'd0;
      d0        <= '0;
      d1        <= '0;
      done      <= 1'b0;
    end else begin
      inflight <= fifo_read_en;
      occ      <= occ_next;
      done     <= 1'b0;
      if (fifo_read_en) remaining <= remaining - LEN_WIDTH'(1);
      if (pop) d0 <= (occ == 2'd2) ? d1 : fifo_data;
      else if (inflight && occ == 2'd0) d0 <= fifo_data;
      if (inflight && occ_next == 2'd2) d1 <= fifo_data;
      case (state)
        IDLE: if (start) begin
          if (burst_len == '0) done <= 1'b1;
          else begin
            state     <= READ;
            remaining <= burst_len;
          end
        end
        READ: if (remaining == '0) state <= FLUSH;
        FLUSH: if (occ_next == 2'd0) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef FIFO_READER_WORDCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) word_count <= 16'd0;
    else if (pop && word_count != 16'hFFFF) word_count <= word_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: randomized scoreboard bench for fifo_reader with a behavioural FIFO model.
module tb_fifo_reader;
  logic       clk = 1'b0;
  logic       rst, start, busy, done, fifo_read_en, m_valid, m_ready;
  logic       fifo_empty = 1'b1;
  logic [5:0] burst_len;
  logic [7:0] fifo_data = 8'h00;
  logic [7:0] m_data;
  logic       wr_en;
  logic [7:0] wr_data;
`ifdef FIFO_READER_WORDCNT_EN
  logic [15:0] word_count;
`endif
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic [7:0] src[$];
  int cyc = 0, c0 = 0, tests = 0, fails = 0, wr_pct = 100, rmode = 0;
  int cur_len = 0, hs_cnt = 0, rd_cnt = 0, hs_total = 0, dc = 0, fv = 0;
  bit armed = 1'b0, prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = 8'h00;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_WIDTH(8), .LEN_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .busy(busy), .done(done),
    .fifo_empty(fifo_empty), .fifo_read_en(fifo_read_en), .fifo_data(fifo_data),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
`ifdef FIFO_READER_WORDCNT_EN
    , .word_count(word_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // synchronous FIFO with one-cycle registered read latency and registered empty flag
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_read_en && fq.size() != 0) fifo_data <= fq.pop_front();
    if (wr_en) fq.push_back(wr_data);
    fifo_empty <= fq.size() == 0;
  end

  initial begin
    wr_en = 1'b0;
    wr_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (src.size() != 0 && $urandom_range(0, 99) < wr_pct) begin
        wr_en = 1'b1;
        wr_data = src.pop_front();
        exp_q.push_back(wr_data);
      end else wr_en = 1'b0;
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // monitor: every downstream word must be the next FIFO word in write order
  always @(negedge clk) begin
    if (rst) begin
      hs_cnt = 0;
      rd_cnt = 0;
      hs_total = 0;
      armed = 1'b0;
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_d);
      end
      chk("busy", busy, armed && cyc > c0 && !done);
      if (fifo_read_en) begin
        rd_cnt++;
        chk("read_while_empty", fifo_empty, 0);
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        hs_total++;
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("data", m_data, exp_q.pop_front());
      end
      if (done) begin
        chk("burst_words", hs_cnt, cur_len);
        chk("burst_reads", rd_cnt, cur_len);
        hs_cnt = 0;
        rd_cnt = 0;
        armed = 1'b0;
      end
      prev_v = m_valid;
      prev_r = m_ready;
      prev_d = m_data;
    end
  end

  task automatic wait_writes();
    for (int i = 0; i < 500 && src.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
  endtask

  task automatic burst_start(input int len, input bit dup);
    @(posedge clk);
    #1;
    start = 1'b1;
    burst_len = 6'(len);
    cur_len = len;
    c0 = cyc;
    armed = len != 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    burst_len = 6'($urandom);
    if (dup) begin
      @(posedge clk);
      #1;
      start = 1'b1;
      burst_len = 6'($urandom_range(1, 63));
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input int lim, output int at);
    bit found = 1'b0;
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
    chk("done_timeout", found, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    burst_len = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read_en", fifo_read_en, 0);
    chk("rst_m_data", m_data, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    // preloaded burst of 4 with downstream always ready
    for (int i = 0; i < 4; i++) src.push_back(8'(8'h11 + i));
    wait_writes();
    burst_start(4, 1'b0);
    fv = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid) begin
        fv = cyc - c0;
        break;
      end
    end
    chk("first_valid_latency", fv, 3);
    wait_done(50, dc);
    chk("done_latency", dc - c0, 7);
    chk("fifo_drained", fq.size(), 0);
    // downstream stalled: only two reads may be outstanding
    for (int i = 0; i < 4; i++) src.push_back(8'(8'h21 + i));
    wait_writes();
    rmode = 1;
    burst_start(4, 1'b0);
    while (cyc < c0 + 10) @(negedge clk);
    chk("stalled_reads", rd_cnt, 2);
    chk("stalled_valid", m_valid, 1);
    chk("stalled_data", m_data, 8'h21);
    rmode = 0;
    wait_done(100, dc);
    // empty FIFO at start, words trickle in
    burst_start(2, 1'b0);
    while (cyc < c0 + 4) @(negedge clk);
    src.push_back(8'hA5);
    repeat (3) @(negedge clk);
    src.push_back(8'h5A);
    wait_done(100, dc);
    // zero-length burst
    burst_start(0, 1'b0);
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    // reset mid-burst with a full skid buffer
    for (int i = 0; i < 6; i++) src.push_back(8'($urandom));
    wait_writes();
    rmode = 1;
    burst_start(6, 1'b0);
    while (cyc < c0 + 6) @(negedge clk);
    chk("pre_rst_valid", m_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_read_en", fifo_read_en, 0);
    chk("lost_words", fq.size(), 4);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q = fq;
    rmode = 0;
    burst_start(1, 1'b0);
    wait_done(100, dc);
    // randomized bursts, random writer rate and backpressure, ignored restarts
    for (int b = 0; b < 30; b++) begin
      int len;
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
      wr_pct = $urandom_range(20, 100);
      rmode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      for (int i = 0; i < len; i++) src.push_back(8'($urandom));
      burst_start(len, len != 0 && $urandom_range(0, 1) == 1);
      wait_done(500, dc);
    end
    rmode = 0;
    repeat (5) @(negedge clk);
    chk("residue", exp_q.size(), fq.size());
`ifdef FIFO_READER_WORDCNT_EN
    chk("word_count", word_count, hs_total);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
